// File: rtl/gfau_padd_ctrl.sv
// gfau_padd_ctrl: sequences one affine point addition P3 = P1 + P2 as nine GFAU commands.
module gfau_padd_ctrl #(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [SIZE-1:0] i_x1,
  input  logic [SIZE-1:0] i_y1,
  input  logic [SIZE-1:0] i_x2,
  input  logic [SIZE-1:0] i_y2,
  input  logic [SIZE-1:0] i_prime,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err,
  output logic [SIZE-1:0] o_x3,
  output logic [SIZE-1:0] o_y3,
  output logic [SIZE-1:0] o_gfau_in_0,
  output logic [SIZE-1:0] o_gfau_in_1,
  output logic [SIZE-1:0] o_gfau_prime,
  output logic [1:0]      o_gfau_op,
  output logic            o_gfau_start,
  input  logic            i_gfau_done,
  input  logic [SIZE-1:0] i_gfau_result
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, DONE} state_t;
  state_t r_state, w_next;
  logic [SIZE-1:0] r_rf [12];
  logic [SIZE-1:0] r_x3, r_y3, w_in0, w_in1;
  logic [3:0]      r_step, w_a, w_b, w_dst;
  logic [1:0]      w_op;
  logic [13:0]     w_rom;
  logic [CW-1:0]   r_cnt;
  logic            r_err, w_cmd, w_last, w_timeout;
  // {a, b, op, dst}; indices 0..4 x1,y1,x2,y2,p; 5..10 t0..t5; 11 lam; 12 x3; 13 y3
  always_comb begin
    w_rom = '0;
    case (r_step)
      4'd0: w_rom = {4'd3,  4'd1,  2'd1, 4'd5};
      4'd1: w_rom = {4'd2,  4'd0,  2'd1, 4'd6};
      4'd2: w_rom = {4'd5,  4'd6,  2'd3, 4'd11};
      4'd3: w_rom = {4'd11, 4'd11, 2'd2, 4'd7};
      4'd4: w_rom = {4'd7,  4'd0,  2'd1, 4'd8};
      4'd5: w_rom = {4'd8,  4'd2,  2'd1, 4'd12};
      4'd6: w_rom = {4'd0,  4'd12, 2'd1, 4'd9};
      4'd7: w_rom = {4'd11, 4'd9,  2'd2, 4'd10};
      4'd8: w_rom = {4'd10, 4'd1,  2'd1, 4'd13};
      default: w_rom = '0;
    endcase
  end
  assign {w_a, w_b, w_op, w_dst} = w_rom;
  assign w_in0     = (w_a == 4'd12) ? r_x3 : r_rf[w_a];
  assign w_in1     = (w_b == 4'd12) ? r_x3 : r_rf[w_b];
  assign w_cmd     = (r_state == ISSUE) || (r_state == WAIT);
  assign w_last    = (r_step == 4'd8);
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
  assign o_busy       = w_cmd || (r_state == CHECK);
  assign o_done       = (r_state == DONE);
  assign o_err        = r_err;
  assign o_x3         = r_x3;
  assign o_y3         = r_y3;
  assign o_gfau_start = (r_state == ISSUE);
  assign o_gfau_in_0  = w_cmd ? w_in0 : '0;
  assign o_gfau_in_1  = w_cmd ? w_in1 : '0;
  assign o_gfau_op    = w_cmd ? w_op : 2'd0;
  assign o_gfau_prime = r_rf[4];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_start ? CHECK : IDLE;
      CHECK:   w_next = (r_rf[0] == r_rf[2]) ? DONE : ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = i_gfau_done ? (w_last ? DONE : ISSUE) : (w_timeout ? DONE : WAIT);
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 12; i++) r_rf[i] <= '0;
      r_x3   <= '0;
      r_y3   <= '0;
      r_step <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_rf[0] <= i_x1;
          r_rf[1] <= i_y1;
          r_rf[2] <= i_x2;
          r_rf[3] <= i_y2;
          r_rf[4] <= i_prime;
          r_x3    <= '0;
          r_y3    <= '0;
          r_err   <= 1'b0;
        end
        CHECK: begin
          r_step <= '0;
          if (r_rf[0] == r_rf[2]) r_err <= 1'b1;
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (i_gfau_done) begin
            if (w_dst == 4'd12) r_x3 <= i_gfau_result;
            else if (w_dst == 4'd13) r_y3 <= i_gfau_result;
            else r_rf[w_dst] <= i_gfau_result;
            if (!w_last) r_step <= r_step + 1'b1;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            r_x3  <= '0;
            r_y3  <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
